// File: rtl/result_writeback_if.sv
// Memory write-master bus used by the result writeback engine.
// Uses a waitrequest-style handshake: a write is accepted when mem_write=1 and mem_waitrequest=0.
interface result_writeback_if #(
  parameter int ADDR_W = 32,
  parameter int MEM_W  = 64
);
  logic              mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [MEM_W-1:0]  mem_writedata;
  logic              mem_waitrequest;

  modport master (
    output mem_write,
    output mem_address,
    output mem_writedata,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_write,
    input  mem_address,
    input  mem_writedata,
    output mem_waitrequest
  );
endinterface

// File: rtl/result_writeback.sv
// Snapshots the MAC accumulator results on start and drains them to memory,
// one zero-extended write per lane, then pulses done.
module result_writeback #(
  parameter int NUM_RESULTS = 8,
  parameter int DATA_W      = 24,
  parameter int MEM_W       = 64,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [DATA_W-1:0]     results [NUM_RESULTS],
  result_writeback_if.master    mem,
  output logic                  busy,
  output logic                  done
);

  localparam int IDX_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_RESULTS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  snap_q [NUM_RESULTS];
  logic [DATA_W-1:0]  snap_d [NUM_RESULTS];
  logic               write_q, write_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [MEM_W-1:0]   wdata_q, wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   idx_inc;

  function automatic logic [MEM_W-1:0] zext(input logic [DATA_W-1:0] v);
    return {{(MEM_W - DATA_W){1'b0}}, v};
  endfunction

  assign idx_inc = idx_q + IDX_W'(1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = results;
          idx_d   = '0;
          busy_d  = 1'b1;
          write_d = 1'b1;
          addr_d  = base_addr;
          wdata_d = zext(results[0]);
          state_d = WRITE;
        end
      end
      WRITE: begin
        // Everything holds while the memory stalls; only an accepted write advances.
        if (write_q && !mem.mem_waitrequest) begin
          if (idx_q == LAST_IDX) begin
            write_d = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            idx_d   = idx_inc;
            addr_d  = addr_q + ADDR_W'(ADDR_STRIDE);
            wdata_d = zext(snap_q[idx_inc]);
          end
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        idx_d   = '0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < NUM_RESULTS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < NUM_RESULTS; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  assign mem.mem_write     = write_q;
  assign mem.mem_address   = addr_q;
  assign mem.mem_writedata = wdata_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_result_writeback.sv
// Directed bench for result_writeback: drains, stalls, snapshot isolation,
// address wrap, mid-transfer reset and back-to-back transfers.
module tb_result_writeback;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base_addr = 32'h0;
  logic [23:0] results [N];
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_data [N];
  int          stall_cycles [N];
  int          poke_at = -1;
  int          reset_at = -1;
  bit          start_in_done = 1'b0;

  result_writeback_if #(.ADDR_W(32), .MEM_W(64)) mem_if ();

  result_writeback dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .results   (results),
    .mem       (mem_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] base);
    base_addr = base;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic loadPattern();
    for (int i = 0; i < N; i++) begin
      results[i]      = 24'h000100 * 24'(i + 1);
      exp_data[i]     = 24'h000100 * 24'(i + 1);
      stall_cycles[i] = 0;
    end
  endtask

  // Walks a transfer already accepted one edge ago, checking every write cycle.
  task automatic drainTransfer(input logic [31:0] base, input int done_cycle);
    logic [31:0] addr;
    int cyc;
    addr = base;
    cyc  = 1;
    for (int n = 0; n < N; n++) begin
      if (n == reset_at) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_write", 64'(mem_if.mem_write), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_address", 64'(mem_if.mem_address), 64'd0);
        return;
      end
      if (n == poke_at) begin
        for (int k = 0; k < N; k++) results[k] = 24'hFFFFFF;
        start     = 1'b1;
        base_addr = 32'hDEAD_BEE0;
      end
      for (int s = 0; s <= stall_cycles[n]; s++) begin
        mem_if.mem_waitrequest = (s < stall_cycles[n]);
        checkOutput($sformatf("write%0d_req", n), 64'(mem_if.mem_write), 64'd1);
        checkOutput($sformatf("write%0d_addr", n), 64'(mem_if.mem_address), 64'(addr));
        checkOutput($sformatf("write%0d_data", n), mem_if.mem_writedata, {40'h0, exp_data[n]});
        checkOutput($sformatf("write%0d_busy", n), 64'(busy), 64'd1);
        checkOutput($sformatf("write%0d_done", n), 64'(done), 64'd0);
        tick();
        cyc++;
        start = 1'b0;
      end
      addr = addr + 32'd8;
    end
    mem_if.mem_waitrequest = 1'b0;
    checkOutput("done_pulse", 64'(done), 64'd1);
    checkOutput("done_mem_write", 64'(mem_if.mem_write), 64'd0);
    checkOutput("done_busy", 64'(busy), 64'd1);
    checkOutput("done_cycle", 64'(cyc), 64'(done_cycle));
    if (start_in_done) begin
      start     = 1'b1;
      base_addr = 32'h0BAD_0000;
    end
    tick();
    start = 1'b0;
    checkOutput("after_done", 64'(done), 64'd0);
    checkOutput("after_busy", 64'(busy), 64'd0);
    checkOutput("after_mem_write", 64'(mem_if.mem_write), 64'd0);
  endtask

  // Idle cycles with waitrequest high: nothing may start and no stray done may appear.
  task automatic checkQuiet(input string tag, input int cycles);
    mem_if.mem_waitrequest = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      tick();
      checkOutput({tag, "_done"}, 64'(done), 64'd0);
      checkOutput({tag, "_write"}, 64'(mem_if.mem_write), 64'd0);
      checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    end
    mem_if.mem_waitrequest = 1'b0;
  endtask

  initial begin
    mem_if.mem_waitrequest = 1'b0;
    loadPattern();
    #12;
    checkOutput("reset_mem_write", 64'(mem_if.mem_write), 64'd0);
    checkOutput("reset_address", 64'(mem_if.mem_address), 64'd0);
    checkOutput("reset_data", mem_if.mem_writedata, 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] basic drain");
    applyStimulus(32'h0000_1000);
    drainTransfer(32'h0000_1000, 9);
    checkQuiet("basic_idle", 2);

    $display("[TB] backpressure");
    stall_cycles[0] = 3;
    stall_cycles[5] = 2;
    applyStimulus(32'h0000_2000);
    drainTransfer(32'h0000_2000, 14);
    loadPattern();

    $display("[TB] snapshot isolation and ignored start");
    poke_at = 2;
    applyStimulus(32'h0000_3000);
    drainTransfer(32'h0000_3000, 9);
    poke_at = -1;
    checkQuiet("snap_idle", 3);
    loadPattern();

    $display("[TB] zero extension and address wrap");
    results[7]  = 24'hFFFFFF;
    exp_data[7] = 24'hFFFFFF;
    applyStimulus(32'hFFFF_FFF0);
    drainTransfer(32'hFFFF_FFF0, 9);
    loadPattern();

    $display("[TB] reset mid-transfer");
    reset_at = 4;
    applyStimulus(32'h0000_4000);
    drainTransfer(32'h0000_4000, 9);
    reset_at = -1;
    tick();
    checkOutput("in_reset_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    checkQuiet("post_reset", 2);
    applyStimulus(32'h0000_5000);
    drainTransfer(32'h0000_5000, 9);

    $display("[TB] back-to-back transfers");
    start_in_done = 1'b1;
    applyStimulus(32'h0000_6000);
    drainTransfer(32'h0000_6000, 9);
    start_in_done = 1'b0;
    applyStimulus(32'h0000_7000);
    drainTransfer(32'h0000_7000, 9);
    checkQuiet("final_idle", 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_writeback.md
Name: result_writeback

Overview:
- Drains the eight 24-bit MAC accumulator results of the matrix-vector unit back to memory.
- It is the write-side counterpart of the fetch path, which reads operand bytes from memory into the A/B FIFOs.
- On a start pulse it snapshots all results, then issues one memory write per result over a waitrequest-style master write interface.
- It signals completion so the controller can clear the MACs and begin the next row block.

Parameters:
- NUM_RESULTS, 8, number of result lanes captured and written.
- DATA_W, 24, width of each MAC result.
- MEM_W, 64, memory write data width; results are zero-extended into it.
- ADDR_W, 32, memory byte-address width.
- ADDR_STRIDE, 8, byte increment between consecutive result writes.

Ports:
- clk  input  1  system clock; all state changes on posedge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to capture results and begin writeback.
- base_addr  input  ADDR_W  byte address for result 0; sampled when start is accepted.
- results  input  NUM_RESULTS x DATA_W  MAC outputs (unpacked array, index 0..NUM_RESULTS-1).
- mem_write  output  1  write request to memory.
- mem_address  output  ADDR_W  write byte address.
- mem_writedata  output  MEM_W  write data.
- mem_waitrequest  input  1  memory stall; a write is accepted on a cycle where mem_write=1 and mem_waitrequest=0.
- busy  output  1  high from start acceptance until done.
- done  output  1  one-cycle pulse after the last write is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; index=0; mem_write=0; mem_address=0; mem_writedata=0; busy=0; done=0; snapshot registers=0.
- All outputs are registered.
- States: IDLE, WRITE, DONE.
- IDLE:
  - start=1 is accepted at the posedge.
  - At that edge: snapshot all results[]; latch base_addr; index=0; busy=1.
  - Also at that edge: mem_write=1, mem_address=base_addr, mem_writedata={zero-ext results[0]}; go to WRITE.
  - First write request is therefore visible the cycle after start.
- WRITE:
  - mem_write, mem_address and mem_writedata hold stable while mem_waitrequest=1 (no change, no drop).
  - On an accepted write with index<NUM_RESULTS-1: index++; mem_address += ADDR_STRIDE; mem_writedata = zero-extended snapshot[index+1]; mem_write stays 1, so back-to-back writes are possible.
  - On an accepted write with index=NUM_RESULTS-1: mem_write=0; done=1; go to DONE.
- DONE (one cycle): done returns to 0; busy=0; index=0; go to IDLE.
- Minimum latency (waitrequest always 0): start at cycle 0, writes accepted at cycles 1..NUM_RESULTS, done high in cycle NUM_RESULTS+1, busy low from cycle NUM_RESULTS+2.
- start while busy=1 (WRITE or DONE) is ignored: no re-snapshot, no address change.
- Snapshot isolation: changes on results[] after start acceptance do not affect written data. The controller may pulse Clr during WRITE.
- Write data: bits [DATA_W-1:0]=result, bits [MEM_W-1:DATA_W]=0. No sign extension.
- Address arithmetic wraps modulo 2^ADDR_W; no error on wrap.
- Reset asserted mid-transfer: immediate return to reset values; mem_write drops asynchronously; the partial transfer is abandoned with no done pulse.
- mem_waitrequest is ignored while mem_write=0.

Test Plan:
- Basic drain: results[i]=24'h000100*(i+1), base_addr=32'h0000_1000, waitrequest=0, start pulse -> 8 consecutive writes to 0x1000,0x1008,...,0x1038 with data 0x100..0x800 zero-extended; done pulse exactly one cycle after the 8th write; busy high for 9 cycles.
- Backpressure: waitrequest=1 for 3 cycles on write 0 and 2 cycles on write 5 -> address/data/mem_write held constant during stalls; total 8 accepted writes; done 5 cycles later than the no-stall case.
- Snapshot and ignored start: change all results to 24'hFFFFFF and pulse start during write 2 -> written data remains the original snapshot values; no second transfer; only one done pulse.
- Zero-extension and wrap: results[7]=24'hFFFFFF, base_addr=32'hFFFF_FFF0 -> write 7 data=64'h0000_0000_00FF_FFFF; addresses 0xFFFFFFF0,0xFFFFFFF8,0x0,...,0x28.
- Reset mid-operation: assert rst_n=0 during write 4 -> mem_write=0 and busy=0 immediately, no done pulse; after release, a new start performs a full 8-write transfer from index 0.
- Back-to-back transfers: start asserted in the cycle done is high is ignored; start one cycle later (IDLE) is accepted, giving a second full transfer with the new base_addr.
